// File: rtl/jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_tap_ctrl
//
// IEEE 1149.1-style TAP controller. Runs the 16-state TAP FSM from TMS, holds
// the instruction register and decodes it into one-hot user-chain selects.
// It drives the shared scan strobes for the user chains and hosts the built-in
// BYPASS and (optionally) IDCODE data registers. TDO is muxed from the
// selected source.
//
// Optional feature macro: JTAG_TAP_IDCODE_EN
//   defined   : 32-bit IDCODE register present. Opcode 2**IR_WIDTH-2 selects
//               it, and reset/Test-Logic-Reset load that opcode.
//   undefined : no IDCODE register. Opcode 2**IR_WIDTH-2 acts as BYPASS, and
//               reset/Test-Logic-Reset load the BYPASS opcode (all ones).
//
// Ports:
//   clk           in   TCK; all state updates on the rising edge
//   reset         in   synchronous active-high reset (TRST equivalent)
//   tms, tdi      in   JTAG pins
//   tdo           out  JTAG TDO (0 when not shifting)
//   tdo_en        out  TDO drive enable, high only in Shift-DR / Shift-IR
//   chain_tck     out  clk forwarded to the user chains
//   chain_treset  out  high while in Test-Logic-Reset
//   chain_tdi     out  tdi forwarded to the user chains
//   chain_sel     out  [NUM_CHAINS] one-hot; bit k set when the IR holds opcode k
//   chain_shift   out  FSM in Shift-DR
//   chain_capture out  FSM in Capture-DR
//   chain_update  out  FSM in Update-DR
//   chain_tdo     in   [NUM_CHAINS] serial output of each user chain
//   ir_out        out  [IR_WIDTH] current (updated) instruction
// -----------------------------------------------------------------------------
module jtag_tap_ctrl #(
    parameter int unsigned NUM_CHAINS   = 4,
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic                  chain_tck,
    output logic                  chain_treset,
    output logic                  chain_tdi,
    output logic [NUM_CHAINS-1:0] chain_sel,
    output logic                  chain_shift,
    output logic                  chain_capture,
    output logic                  chain_update,
    input  logic [NUM_CHAINS-1:0] chain_tdo,
    output logic [IR_WIDTH-1:0]   ir_out
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_e;

    localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = {{(IR_WIDTH-1){1'b1}}, 1'b0};
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_RESET  = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] OP_RESET  = OP_BYPASS;
`endif

    state_e                state_q, state_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
    logic                  bypass_q, bypass_d;

    // Instruction decode
    logic                  op_chain;
    logic                  op_idcode;
    logic                  op_bypass;
    logic                  sel_chain_tdo;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= TLR;
        else       state_q <= state_d;
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic (standard TMS transitions)
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // ---------------------------------------------------------------------
    // Instruction decode (from the updated IR only, stable during DR scans)
    // ---------------------------------------------------------------------
    always_comb begin
        op_chain      = 1'b0;
        sel_chain_tdo = 1'b0;
        chain_sel     = '0;
        for (int k = 0; k < int'(NUM_CHAINS); k++) begin
            if (ir_q == IR_WIDTH'(k)) begin
                chain_sel[k]  = 1'b1;
                op_chain      = 1'b1;
                sel_chain_tdo = chain_tdo[k];
            end
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    assign op_idcode = (ir_q == OP_IDCODE);
`else
    assign op_idcode = 1'b0;
`endif
    // Unused opcodes fall through to BYPASS
    assign op_bypass = !op_chain && !op_idcode;

    // ---------------------------------------------------------------------
    // FSM: output decode (strobes and TDO mux)
    // ---------------------------------------------------------------------
    logic idcode_lsb;

    always_comb begin
        chain_treset  = (state_q == TLR);
        chain_capture = (state_q == CAP_DR);
        chain_shift   = (state_q == SH_DR);
        chain_update  = (state_q == UPD_DR);
        tdo_en        = (state_q == SH_DR) || (state_q == SH_IR);
        tdo           = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            if (op_chain)       tdo = sel_chain_tdo;
            else if (op_idcode) tdo = idcode_lsb;
            else                tdo = bypass_q;
        end
    end

    assign chain_tck = clk;
    assign chain_tdi = tdi;
    assign ir_out    = ir_q;

    // ---------------------------------------------------------------------
    // Instruction register and its shift stage
    // ---------------------------------------------------------------------
    always_comb begin
        ir_sr_d = ir_sr_q;
        ir_d    = ir_q;
        case (state_q)
            CAP_IR:  ir_sr_d = IR_WIDTH'(1);
            SH_IR:   ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            UPD_IR:  ir_d    = ir_sr_q;
            default: ;
        endcase
        // Entering (or sitting in) Test-Logic-Reset forces the default opcode
        if (state_d == TLR) ir_d = OP_RESET;
    end

    // ---------------------------------------------------------------------
    // BYPASS register
    // ---------------------------------------------------------------------
    always_comb begin
        bypass_d = bypass_q;
        if (op_bypass) begin
            if (state_q == CAP_DR)     bypass_d = 1'b0;
            else if (state_q == SH_DR) bypass_d = tdi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q     <= OP_RESET;
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
        end
    end

    // ---------------------------------------------------------------------
    // IDCODE register
    // ---------------------------------------------------------------------
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (op_idcode) begin
            if (state_q == CAP_DR)     idcode_d = IDCODE_VALUE;
            else if (state_q == SH_DR) idcode_d = {tdi, idcode_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idcode_q <= '0;
        else       idcode_q <= idcode_d;
    end

    assign idcode_lsb = idcode_q[0];
`else
    // Without the IDCODE register the ID value has no sink
    logic idcode_unused;
    assign idcode_unused = ^IDCODE_VALUE;
    assign idcode_lsb    = 1'b0;
`endif

endmodule
